// File: rtl/rapcores_wb_pkg.sv
// Shared Wishbone host definitions for the rapcores bus masters.
package rapcores_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  // Data returned alongside an error response.
  localparam logic [WB_DATA_W-1:0] WB_ERR_DATA = 32'h0;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUS  = 2'd1,
    WB_RESP = 2'd2
  } wb_state_e;

  // Response payload as presented on the response channel.
  typedef struct packed {
    logic                 err;
    logic [WB_DATA_W-1:0] dat;
  } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating cycle counter with a registered flag marking count == LIMIT-1.
module wb_timeout_ctr #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] SAT  = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment until saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != SAT)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register; hit tracks the next count so it lines up with count_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hit     <= (LAST == '0);
    end else begin
      count_q <= count_d;
      hit     <= (count_d == LAST);
    end
  end

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master with valid/ready command and response channels.
module wb_host_master
  import rapcores_wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,

  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,

  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CTR_W = $clog2(TIMEOUT + 1);

  wb_state_e         state_q, state_d;
  wb_rsp_t           rsp_q, rsp_d;
  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic              cyc_d, stb_d, we_d;
  logic [SEL_W-1:0]  sel_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] dat_d;
  logic              ctr_clr, ctr_en, ctr_hit;

  assign rsp_dat_o = rsp_q.dat;
  assign rsp_err_o = rsp_q.err;

  // Bounds how long a transfer may wait for the slave's ack.
  wb_timeout_ctr #(
    .LIMIT (TIMEOUT),
    .W     (CTR_W)
  ) u_timeout_ctr (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .clr   (ctr_clr),
    .en    (ctr_en),
    .hit   (ctr_hit)
  );

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    rsp_d       = rsp_q;
    cmd_ready_d = cmd_ready_o;
    rsp_valid_d = rsp_valid_o;
    cyc_d       = wbm_cyc_o;
    stb_d       = wbm_stb_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    ctr_clr     = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      WB_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cmd_ready_d = 1'b0;
          ctr_clr     = 1'b1;
          state_d     = WB_BUS;
        end
      end

      WB_BUS: begin
        ctr_en = !wbm_ack_i;
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_d.err   = 1'b0;
          rsp_d.dat   = wbm_we_o ? DATA_W'(0) : wbm_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = WB_RESP;
        end else if (ctr_hit) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_d.err   = 1'b1;
          rsp_d.dat   = WB_ERR_DATA;
          rsp_valid_d = 1'b1;
          state_d     = WB_RESP;
        end
      end

      WB_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = WB_IDLE;
        end
      end

      default: begin
        state_d     = WB_IDLE;
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= WB_IDLE;
      rsp_q       <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_q       <= rsp_d;
      cmd_ready_o <= cmd_ready_d;
      rsp_valid_o <= rsp_valid_d;
      wbm_cyc_o   <= cyc_d;
      wbm_stb_o   <= stb_d;
      wbm_we_o    <= we_d;
      wbm_sel_o   <= sel_d;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed and randomized transfers against wb_host_master with TIMEOUT = 8.
module tb_wb_host_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr, wbm_dat_out, wbm_dat_in;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_host_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_out),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_dat_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic scramble_cmd();
    cmd_we  = 1'($urandom);
    cmd_adr = $urandom;
    cmd_dat = $urandom;
    cmd_sel = 4'($urandom);
  endtask

  // One complete transfer, starting and ending on a negedge with the master idle.
  // The slave acks in stb cycle wait_n+1; bp cycles of response backpressure.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int unsigned wait_n,
                      input logic [31:0] rdat, input int unsigned bp);
    logic        exp_err;
    logic [31:0] exp_dat;
    int unsigned exp_stb;
    int unsigned stb_cnt;
    int unsigned lat;
    exp_err = (wait_n >= TMO);
    exp_dat = (exp_err || we) ? 32'h0 : rdat;
    exp_stb = exp_err ? TMO : wait_n + 1;

    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble_cmd();
    lat     = 1;
    stb_cnt = 0;

    while (wbm_stb === 1'b1 && stb_cnt < 64) begin
      chk("bus_cyc", 32'(wbm_cyc), 32'd1);
      chk("bus_we", 32'(wbm_we), 32'(we));
      chk("bus_adr", wbm_adr, adr);
      chk("bus_dat", wbm_dat_out, dat);
      chk("bus_sel", 32'(wbm_sel), 32'(sel));
      chk("bus_cmd_ready", 32'(cmd_ready), 32'd0);
      stb_cnt++;
      wbm_ack    = (stb_cnt == wait_n + 1);
      wbm_dat_in = wbm_ack ? rdat : $urandom;
      @(negedge clk);
      lat++;
      wbm_ack    = 1'b0;
      wbm_dat_in = $urandom;
    end
    chk("stb_cycles", stb_cnt, exp_stb);
    chk("cyc_dropped", 32'(wbm_cyc), 32'd0);

    for (int i = 0; i < int'(bp); i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_dat", rsp_dat, exp_dat);
      chk("bp_rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_cyc", 32'(wbm_cyc), 32'd0);
      cmd_valid = 1'b1;
      scramble_cmd();
      wbm_ack = 1'($urandom);
      @(negedge clk);
      lat++;
      wbm_ack = 1'b0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    lat++;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("ready_latency", lat, exp_stb + bp + 2);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_cyc", 32'(wbm_cyc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_adr    = '0;
    cmd_dat    = '0;
    cmd_sel    = '0;
    rsp_ready  = 1'b0;
    wbm_ack    = 1'b0;
    wbm_dat_in = '0;
    repeat (2) @(negedge clk);

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    chk("rst_cyc", 32'(wbm_cyc), 32'd0);
    chk("rst_stb", 32'(wbm_stb), 32'd0);
    chk("rst_we", 32'(wbm_we), 32'd0);
    chk("rst_sel", 32'(wbm_sel), 32'd0);
    chk("rst_adr", wbm_adr, 32'd0);
    chk("rst_dat", wbm_dat_out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait write, back-to-back with a read carrying four wait states.
    xfer(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 0);
    xfer(1'b0, 32'h3000_0010, $urandom, 4'hF, 4, 32'hDEAD_0001, 0);
    // Timeout, then ack landing on the final allowed cycle.
    xfer(1'b0, 32'h3000_0020, $urandom, 4'h3, 100, 32'h5555_AAAA, 0);
    xfer(1'b0, 32'h3000_0024, $urandom, 4'hF, TMO - 1, 32'hCAFE_F00D, 1);
    xfer(1'b1, 32'h3000_0028, 32'h0BAD_BEEF, 4'hC, 100, 32'h7777_7777, 0);
    // Response held off for ten cycles with a competing command pending.
    xfer(1'b0, 32'h3000_0030, $urandom, 4'hF, 2, 32'h1234_5678, 10);

    for (int n = 0; n < 40; n++) begin
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
           $urandom_range(0, TMO + 2), $urandom, $urandom_range(0, 3));
    end

    // Reset during a wait state drops the bus cycle asynchronously.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0040;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_bus_stb", 32'(wbm_stb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(wbm_cyc), 32'd0);
    chk("async_rst_stb", 32'(wbm_stb), 32'd0);
    chk("async_rst_adr", wbm_adr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wbm_ack = 1'(i[0]);
      @(negedge clk);
      chk("after_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("after_rst_cyc", 32'(wbm_cyc), 32'd0);
    end

    // Stray ack while idle produces nothing.
    for (int i = 0; i < 3; i++) begin
      wbm_ack    = 1'b1;
      wbm_dat_in = $urandom;
      @(negedge clk);
      chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("stray_cyc", 32'(wbm_cyc), 32'd0);
    end
    wbm_ack = 1'b0;
    xfer(1'b0, 32'h3000_0044, $urandom, 4'hF, 1, 32'h600D_0002, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
